// File: rtl/rb_arb_pkg.sv
// rtl/rb_arb_pkg.sv - shared types and constants for the register bus arbiter
package rb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // Width of the watchdog counter; it only has to reach TIMEOUT-1
  function automatic int wd_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/rb_rr_pick.sv
// rtl/rb_rr_pick.sv - combinational round-robin requester selector
module rb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // Scan upward from the slot after last_owner, wrapping, and take the first requester
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    any_req   = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_owner) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_req && req[cand_idx]) begin
        any_req   = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (any_req) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rb_bus_arbiter.sv
// rtl/rb_bus_arbiter.sv - round-robin arbiter sharing one register bus between masters
module rb_bus_arbiter
  import rb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      timeout,
  output logic                      wstrobe,
  output logic                      rstrobe,
  output logic [ADDR_W-1:0]         waddr,
  output logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      rack,
  input  logic                      raddrerr,
  input  logic                      wack,
  input  logic                      waddrerr
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               WD_W     = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  dir_q, dir_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_q, timeout_d;
  logic                  wstrobe_q, wstrobe_d;
  logic                  rstrobe_q, rstrobe_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  pick_write;
  logic [ADDR_W-1:0]     pick_addr;
  logic [DATA_W-1:0]     pick_wdata;
  logic                  bus_ack;
  logic                  bus_err;

  rb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .any_req    (pick_any)
  );

  // Select the chosen master's request fields and the response pair matching the latched direction
  always_comb begin
    pick_write = req_write[pick_idx];
    pick_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    pick_wdata = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
    bus_ack    = dir_q ? wack : rack;
    bus_err    = dir_q ? waddrerr : raddrerr;
  end

  // Next-state and next-output computation for the IDLE/ACCESS/DONE sequence
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wd_d        = wd_q;
    dir_d       = dir_q;
    grant_d     = grant_q;
    done_d      = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = 1'b0;
    wstrobe_d   = wstrobe_q;
    rstrobe_d   = rstrobe_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d   = ST_ACCESS;
          last_d    = pick_idx;
          grant_d   = pick_grant;
          dir_d     = pick_write;
          wd_d      = '0;
          wstrobe_d = pick_write;
          rstrobe_d = !pick_write;
          waddr_d   = pick_write ? pick_addr : '0;
          raddr_d   = pick_write ? '0 : pick_addr;
          wdata_d   = pick_write ? pick_wdata : '0;
        end
      end
      ST_ACCESS: begin
        if (bus_ack || bus_err || (wd_q == WD_LAST)) begin
          state_d     = ST_DONE;
          done_d      = grant_q;
          wstrobe_d   = 1'b0;
          rstrobe_d   = 1'b0;
          waddr_d     = '0;
          raddr_d     = '0;
          wdata_d     = '0;
          // A real response on the expiry cycle takes precedence over the watchdog
          if (bus_ack || bus_err) begin
            rsp_err_d   = bus_err;
            rsp_rdata_d = (!dir_q && bus_ack && !bus_err) ? rdata : '0;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            timeout_d   = 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        wd_d        = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RST;
      wd_q        <= '0;
      dir_q       <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      wstrobe_q   <= 1'b0;
      rstrobe_q   <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      dir_q       <= dir_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
      wstrobe_q   <= wstrobe_d;
      rstrobe_q   <= rstrobe_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign timeout   = timeout_q;
  assign wstrobe   = wstrobe_q;
  assign rstrobe   = rstrobe_q;
  assign waddr     = waddr_q;
  assign raddr     = raddr_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_rb_bus_arbiter.sv
// tb/tb_rb_bus_arbiter.sv - self-checking bench for rb_bus_arbiter
module tb_rb_bus_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  grant, done;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err, timeout, wstrobe, rstrobe;
  logic [AW-1:0]  waddr, raddr;
  logic [DW-1:0]  wdata, rdata;
  logic           rack, raddrerr, wack, waddrerr;

  int checks = 0;
  int errors = 0;
  int last_owner;
  int own;

  always #5 clk = ~clk;

  rb_bus_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .timeout   (timeout),
    .wstrobe   (wstrobe),
    .rstrobe   (rstrobe),
    .waddr     (waddr),
    .raddr     (raddr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rack      (rack),
    .raddrerr  (raddrerr),
    .wack      (wack),
    .waddrerr  (waddrerr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_strobes"}, 64'({wstrobe, rstrobe}), 64'd0);
    chk({tag, "_addrs"}, 64'({waddr, raddr}), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata), 64'd0);
  endtask

  // Reference: first requester searching upward from last+1 with wrap-around
  function automatic int rr_next(input int last, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_master(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[m] = w;
    req_addr[m*AW +: AW] = a;
    req_wdata[m*DW +: DW] = d;
    req[m] = 1'b1;
  endtask

  task automatic clear_bus();
    rack = 1'b0; raddrerr = 1'b0; wack = 1'b0; waddrerr = 1'b0; rdata = '0;
  endtask

  // One complete transfer: grant, strobe phase, done, return to idle
  task automatic serve(input int kind, input int delay, input logic [DW-1:0] rval,
                       input bit noise, input bit drop, input bit release_req, output int o);
    int            exp_own, exp_len, k;
    bit            exp_to, exp_err, fin, hit, dir;
    logic [DW-1:0] exp_rd, d;
    logic [AW-1:0] a;
    exp_own = rr_next(last_owner, req);
    dir = req_write[exp_own];
    a   = req_addr[exp_own*AW +: AW];
    d   = req_wdata[exp_own*DW +: DW];
    if (kind == K_NONE || delay >= TO) begin
      exp_len = TO; exp_to = 1'b1; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_len = delay + 1; exp_to = 1'b0; exp_err = (kind != K_ACK);
      exp_rd  = (kind == K_ACK && !dir) ? rval : '0;
    end
    @(posedge clk); #1;
    last_owner = exp_own;
    o = exp_own;
    chk("grant", 64'(grant), 64'd1 << exp_own);
    k = 0; fin = 1'b0;
    while (!fin) begin
      chk("wstrobe", 64'(wstrobe), 64'(dir));
      chk("rstrobe", 64'(rstrobe), 64'(!dir));
      chk("addr", 64'(dir ? waddr : raddr), 64'(a));
      if (dir) chk("wdata", 64'(wdata), 64'(d));
      chk("early_done", 64'(done), 64'd0);
      hit = (kind != K_NONE) && (k == delay);
      if (dir) begin
        wack = hit && (kind != K_ERR); waddrerr = hit && (kind != K_ACK);
        rack = noise ? 1'($urandom) : 1'b0; raddrerr = noise ? 1'($urandom) : 1'b0;
      end else begin
        rack = hit && (kind != K_ERR); raddrerr = hit && (kind != K_ACK);
        wack = noise ? 1'($urandom) : 1'b0; waddrerr = noise ? 1'($urandom) : 1'b0;
      end
      rdata = hit ? rval : $urandom;
      if (noise) begin
        for (int m = 0; m < NR; m++) begin
          req_addr[m*AW +: AW]  = AW'($urandom);
          req_wdata[m*DW +: DW] = $urandom;
        end
      end
      if (drop && k == 1) req[exp_own] = 1'b0;
      @(posedge clk); #1;
      k++;
      if (done !== '0 || k >= TO + 2) fin = 1'b1;
    end
    clear_bus();
    chk("len", 64'(k), 64'(exp_len));
    chk("done", 64'(done), 64'd1 << exp_own);
    chk("grant_in_done", 64'(grant), 64'd1 << exp_own);
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("timeout", 64'(timeout), 64'(exp_to));
    chk("strobes_off", 64'({wstrobe, rstrobe}), 64'd0);
    if (release_req) req[exp_own] = 1'b0;
    @(posedge clk); #1;
    chk("done_1cyc", 64'(done), 64'd0);
    chk("grant_clr", 64'(grant), 64'd0);
    chk("timeout_1cyc", 64'(timeout), 64'd0);
  endtask

  initial begin
    int kind, delay;
    reset = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    clear_bus();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    last_owner = NR - 1;

    // single write with same-cycle ack
    set_master(0, 1'b1, 8'h10, 32'hDEADBEEF);
    serve(K_ACK, 0, '0, 1'b0, 1'b0, 1'b1, own);

    // read with delayed ack
    set_master(1, 1'b0, 8'h24, '0);
    serve(K_ACK, 3, 32'h12345678, 1'b0, 1'b0, 1'b1, own);

    // fairness with two continuous requesters
    set_master(0, 1'b1, 8'h40, 32'h00001111);
    set_master(1, 1'b0, 8'h41, '0);
    for (int i = 0; i < 8; i++) serve(K_ACK, i % 2, $urandom, 1'b0, 1'b0, 1'b0, own);
    req = '0;

    // address error together with ack
    set_master(0, 1'b1, 8'hFC, 32'h0000CAFE);
    serve(K_BOTH, 0, '0, 1'b0, 1'b0, 1'b1, own);

    // watchdog expiry, then a normal transfer
    set_master(1, 1'b0, 8'h30, '0);
    serve(K_NONE, 0, '0, 1'b0, 1'b0, 1'b1, own);
    set_master(1, 1'b0, 8'h31, '0);
    serve(K_ACK, 1, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b1, own);

    // ack on the expiry cycle wins
    set_master(0, 1'b0, 8'h50, '0);
    serve(K_ACK, TO - 1, 32'h00000077, 1'b0, 1'b0, 1'b1, own);

    // reset in the second strobe cycle
    set_master(1, 1'b0, 8'h60, '0);
    @(posedge clk); #1;
    chk("rst_grant", 64'(grant), 64'b010);
    chk("rst_rstrobe0", 64'(rstrobe), 64'd1);
    @(posedge clk); #1;
    chk("rst_rstrobe1", 64'(rstrobe), 64'd1);
    reset = 1'b1;
    req = 3'b101;
    req_write[0] = 1'b1; req_write[2] = 1'b0;
    @(posedge clk); #1;
    check_zero("midreset");
    reset = 1'b0;
    last_owner = NR - 1;
    serve(K_ACK, 0, '0, 1'b0, 1'b0, 1'b1, own);
    chk("post_reset_owner", 64'(own), 64'd0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < NR; m++) begin
        if (!req[m] && ($urandom % 2) == 1) set_master(m, 1'($urandom), AW'($urandom), $urandom);
      end
      if (req == '0) set_master($urandom % NR, 1'($urandom), AW'($urandom), $urandom);
      kind = $urandom % 8;
      delay = $urandom % 4;
      if (kind == 4) kind = K_ERR;
      else if (kind == 5) kind = K_BOTH;
      else if (kind == 6) kind = K_NONE;
      else if (kind == 7) begin kind = K_ACK; delay = $urandom % 18; end
      else kind = K_ACK;
      serve(kind, delay, $urandom, 1'b1, ($urandom % 4) == 0, 1'b1, own);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rb_bus_arbiter.md
Name: rb_bus_arbiter

Overview:
Round-robin arbiter that shares one generic register bus between NUM_REQ masters, for example an APB bridge and an on-chip config loader. Each master presents a single read or write request. The arbiter serialises the requests onto the wstrobe/rstrobe bus, waits for wack/rack or an address error, and returns data and status to the granted master. A watchdog ends any access that is never acknowledged.

Parameters:
NUM_REQ, 2, number of requesting masters (2..8)
ADDR_W, 8, register address width
DATA_W, 32, register data width
TIMEOUT, 16, cycles in ACCESS without ack/err before forced error termination (>=2)

Ports:
clk  in  1  register bus clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-master request; held high until the matching done pulse
req_write  in  NUM_REQ  per-master direction (1 = write)
req_addr  in  NUM_REQ*ADDR_W  per-master address, flattened, master i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  per-master write data, flattened
grant  out  NUM_REQ  one-hot, current owner
done  out  NUM_REQ  one-cycle completion pulse to the owner
rsp_rdata  out  DATA_W  read data, valid with done
rsp_err  out  1  error flag, valid with done
timeout  out  1  one-cycle pulse when the watchdog fires
wstrobe  out  1  bus write strobe
rstrobe  out  1  bus read strobe
waddr  out  ADDR_W  bus write address
raddr  out  ADDR_W  bus read address
wdata  out  DATA_W  bus write data
rdata  in  DATA_W  bus read data
rack  in  1  read acknowledge
raddrerr  in  1  read address error
wack  in  1  write acknowledge
waddrerr  in  1  write address error

Behaviour:
- States: IDLE, ACCESS, DONE. Every output is registered.
- Reset (synchronous): state = IDLE, last_owner = NUM_REQ-1 (master 0 has first priority), watchdog = 0. All outputs are 0.
- IDLE, when any req is high:
  - Pick the first requesting index, searching upward from last_owner+1 with wrap-around.
  - Latch that master's dir/addr/wdata, set grant one-hot and last_owner, then go to ACCESS.
- IDLE with no req: stay in IDLE.
- ACCESS:
  - Drive wstrobe (write) or rstrobe (read) high, with waddr/raddr from the latched address and wdata from the latched data.
  - Addresses and data hold stable for the whole access. The inactive strobe stays 0.
  - Sample only the ack/err pair matching the direction; the opposite pair is ignored.
  - ack or err seen: capture rsp_rdata = rdata (read with ack and no err), otherwise 0. Set rsp_err = err. Go to DONE.
  - err and ack high together: error wins, rsp_rdata = 0.
  - Watchdog increments each cycle without ack/err. When it equals TIMEOUT-1: rsp_err = 1, rsp_rdata = 0, timeout pulse, go to DONE.
  - If ack arrives on the expiry cycle, ack wins and there is no timeout.
- DONE:
  - Strobes are 0. done[owner] is high for exactly one cycle; grant stays asserted this cycle.
  - Next cycle: back to IDLE, grant cleared, watchdog cleared.
- Latency: req sampled at edge N, strobe high after N+1. With a same-cycle ack, done is high after N+2. Minimum 3 cycles per transfer; back-to-back requests alternate fairly between masters.
- A master dropping req mid-access does not abort the access; done is still pulsed.
- req_* inputs are not re-sampled after the grant.
- Reset asserted mid-access: strobes and grant are 0 after the edge, and no done pulse is issued.

Decomposition:
- Package rb_arb_pkg holds:
  - state enum (IDLE/ACCESS/DONE)
  - default ADDR_W/DATA_W constants
  - a function returning the watchdog width, $clog2(TIMEOUT)
- One sub-module, rb_rr_pick: combinational round-robin selector. Inputs: req vector and last_owner. Outputs: one-hot grant and index, plus any_req.

Test Plan:
- Single write: master0 write addr 0x10, data 0xDEADBEEF, wack same cycle as wstrobe -> wstrobe high exactly 1 cycle with waddr = 0x10; done[0] 2 cycles after req; rsp_err = 0.
- Read with delayed ack: master1 read 0x24, rack 3 cycles later with rdata = 0x12345678 -> rstrobe high 4 cycles; rsp_rdata = 0x12345678 with done[1].
- Fairness: both masters request continuously for 4 transfers each -> grant order 0,1,0,1,...; each done exactly once per grant.
- Address error: write 0xFC with waddrerr = 1 and wack = 1 -> rsp_err = 1, rsp_rdata = 0, timeout = 0.
- Watchdog: read with no rack or raddrerr, TIMEOUT = 16 -> rstrobe high 16 cycles, then timeout and rsp_err pulse with done; next request is served normally.
- Reset during ACCESS: assert reset in the 2nd strobe cycle -> all outputs 0 the next cycle, no done pulse; master 0 wins the first post-reset arbitration.
